// File: rtl/demux_pkg.sv
// Shared constants and helpers for the stream_demux_1xn block.
package demux_pkg;

    // Width of the optional beat/drop counters.
    localparam int unsigned DEMUX_CNT_W = 16;

    // Default data width of a beat.
    localparam int unsigned DEMUX_DEFAULT_N = 2;

    // Bit offset of channel k inside a flattened NUM_OUT*N bus.
    function automatic int unsigned slice_off(input int unsigned k, input int unsigned n);
        return k * n;
    endfunction

endpackage

// File: rtl/stream_demux_1xn_if.sv
// Stream bus of the 1-to-NUM_OUT demultiplexer: one input channel and NUM_OUT
// flattened output channels. The slave modport is the demux view; the master
// modport is the producer/consumer view.
interface stream_demux_1xn_if
    import demux_pkg::*;
#(
    parameter int unsigned N       = DEMUX_DEFAULT_N,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned SEL_W   = $clog2(NUM_OUT)
) ();

    logic [N-1:0]         in_data;
    logic [SEL_W-1:0]     in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_OUT*N-1:0] out_data;
    logic [NUM_OUT-1:0]   out_valid;
    logic [NUM_OUT-1:0]   out_ready;
    logic                 drop_err;

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop_err
    );

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop_err
    );

endinterface

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel of the demux.
module demux_slot #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] data_in,
    input  logic         drain_ready,
    output logic         valid,
    output logic [N-1:0] data_out,
    output logic         can_load
);

    logic         valid_q, valid_d;
    logic [N-1:0] data_q, data_d;

    // Next state: a load wins over a drain so drain+load keeps the slot full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
        end else if (drain_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot state register; data is kept (not cleared) when the slot empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid    = valid_q;
    assign data_out = data_q;
    assign can_load = !valid_q | drain_ready;

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-NUM_OUT stream demultiplexer. Each channel owns a one-entry
// slot so a stalled consumer only blocks beats addressed to it. Beats with an
// out-of-range select are accepted and dropped with a one-cycle drop_err pulse.
// Optional feature macro: DEMUX_BEAT_CNT_EN adds per-channel drained-beat
// counters (wrapping) and a saturating drop counter.
module stream_demux_1xn
    import demux_pkg::*;
#(
    parameter int unsigned N       = DEMUX_DEFAULT_N,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    stream_demux_1xn_if.slave             bus
`ifdef DEMUX_BEAT_CNT_EN
    ,
    output logic [NUM_OUT*DEMUX_CNT_W-1:0] beat_cnt,
    output logic [DEMUX_CNT_W-1:0]         drop_cnt
`endif
);

    logic [SEL_W-1:0]     sel;
    logic [31:0]          sel_ext;
    logic                 in_range;
    logic                 ready;
    logic                 accept;
    logic [NUM_OUT-1:0]   load;
    logic [NUM_OUT-1:0]   can_load;
    logic [NUM_OUT-1:0]   valid;
    logic [N-1:0]         slot_data [NUM_OUT];
    logic [NUM_OUT*N-1:0] out_data_flat;
    logic                 drop_q;

    assign sel      = bus.in_sel;
    assign sel_ext  = 32'(sel);
    assign in_range = sel_ext < NUM_OUT;
    assign accept   = bus.in_valid & ready;

    // in_ready follows the addressed slot; out-of-range beats are always taken.
    always_comb begin
        ready = 1'b1;
        if (in_range) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (sel_ext == 32'(k)) begin
                    ready = can_load[k];
                end
            end
        end
    end

    // Select decode: at most one slot loads per cycle.
    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            load[k] = accept & (sel_ext == 32'(k));
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : gen_slot
        demux_slot #(
            .N (N)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .load        (load[g]),
            .data_in     (bus.in_data),
            .drain_ready (bus.out_ready[g]),
            .valid       (valid[g]),
            .data_out    (slot_data[g]),
            .can_load    (can_load[g])
        );
    end

    // Flatten slot contents onto the output data bus.
    always_comb begin
        out_data_flat = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            out_data_flat[slice_off(k, N) +: N] = slot_data[k];
        end
    end

    // Drop pulse: registered so it appears in the cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= accept & ~in_range;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = out_data_flat;
    assign bus.out_valid = valid;
    assign bus.drop_err  = drop_q;

`ifdef DEMUX_BEAT_CNT_EN
    logic [DEMUX_CNT_W-1:0] beat_cnt_q [NUM_OUT];
    logic [DEMUX_CNT_W-1:0] drop_cnt_q;

    // Per-channel drained-beat counters, wrapping at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                beat_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (valid[k] & bus.out_ready[k]) begin
                    beat_cnt_q[k] <= beat_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Drop counter counts drop_err pulses and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop_q && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    // Pack counters onto the flat output.
    always_comb begin
        beat_cnt = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            beat_cnt[slice_off(k, DEMUX_CNT_W) +: DEMUX_CNT_W] = beat_cnt_q[k];
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Self-checking bench for stream_demux_1xn: a 4-channel instance carries the
// routing/stall/throughput/reset scenarios against a per-channel scoreboard,
// and a 3-channel instance exercises the out-of-range drop path.
module tb_stream_demux_1xn;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    stream_demux_1xn_if #(.N(8), .NUM_OUT(4)) bus4 ();
    stream_demux_1xn_if #(.N(8), .NUM_OUT(3)) bus3 ();

`ifdef DEMUX_BEAT_CNT_EN
    logic [63:0] beat_cnt4;
    logic [15:0] drop_cnt4;
    logic [47:0] beat_cnt3;
    logic [15:0] drop_cnt3;
`endif

    stream_demux_1xn #(.N(8), .NUM_OUT(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus4)
`ifdef DEMUX_BEAT_CNT_EN
        ,
        .beat_cnt (beat_cnt4),
        .drop_cnt (drop_cnt4)
`endif
    );

    stream_demux_1xn #(.N(8), .NUM_OUT(3)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus3)
`ifdef DEMUX_BEAT_CNT_EN
        ,
        .beat_cnt (beat_cnt3),
        .drop_cnt (drop_cnt3)
`endif
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [4][$];
    logic [7:0] sb_exp;

    // Scoreboard: push on accepted beats, pop and compare on drained beats.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (bus4.out_valid[k] && bus4.out_ready[k]) begin
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected ch%0d: got %h, required no beat",
                                 k, bus4.out_data[k*8 +: 8]);
                    end else begin
                        sb_exp = exp_q[k].pop_front();
                        if (bus4.out_data[k*8 +: 8] !== sb_exp) begin
                            errors++;
                            $display("FAIL sb_data ch%0d: got %h, required %h",
                                     k, bus4.out_data[k*8 +: 8], sb_exp);
                        end
                    end
                end
            end
            if (bus4.in_valid && bus4.in_ready) begin
                exp_q[bus4.in_sel].push_back(bus4.in_data);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus4.in_data = '0; bus4.in_sel = '0; bus4.in_valid = 1'b0; bus4.out_ready = '0;
        bus3.in_data = '0; bus3.in_sel = '0; bus3.in_valid = 1'b0; bus3.out_ready = '0;
        @(negedge clk);
        checks++;
        if (bus4.out_valid !== 4'h0) begin
            errors++; $display("FAIL rst_out_valid: got %h, required 0", bus4.out_valid);
        end
        checks++;
        if (bus4.out_data !== 32'h0) begin
            errors++; $display("FAIL rst_out_data: got %h, required 0", bus4.out_data);
        end
        checks++;
        if (bus4.drop_err !== 1'b0) begin
            errors++; $display("FAIL rst_drop_err: got %b, required 0", bus4.drop_err);
        end
        checks++;
        if (bus4.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_in_ready: got %b, required 1", bus4.in_ready);
        end
        checks++;
        if (bus3.out_valid !== 3'h0) begin
            errors++; $display("FAIL rst3_out_valid: got %h, required 0", bus3.out_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_route();
        logic [3:0] exp_v;
        bus4.out_ready = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i < 4) begin
                bus4.in_data  = 8'(32'hA1 + 32'h11 * i);
                bus4.in_sel   = 2'(i);
                bus4.in_valid = 1'b1;
            end else begin
                bus4.in_valid = 1'b0;
            end
            @(negedge clk);
            exp_v = 4'h0;
            if (i >= 1 && i <= 4) exp_v = 4'(1 << (i - 1));
            checks++;
            if (bus4.out_valid !== exp_v) begin
                errors++;
                $display("FAIL route_valid step%0d: got %b, required %b", i, bus4.out_valid, exp_v);
            end
            if (i < 4) begin
                checks++;
                if (bus4.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL route_ready step%0d: got %b, required 1", i, bus4.in_ready);
                end
            end
        end
    endtask

    task automatic test_stall();
        bus4.out_ready = 4'b1011;
        @(posedge clk); #1;
        bus4.in_data = 8'h11; bus4.in_sel = 2'd2; bus4.in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus4.in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_first_ready: got %b, required 1", bus4.in_ready);
        end
        @(posedge clk); #1;
        bus4.in_data = 8'h22;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus4.in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_blocked c%0d: got %b, required 0", c, bus4.in_ready);
            end
            checks++;
            if (bus4.out_valid[2] !== 1'b1 || bus4.out_data[23:16] !== 8'h11) begin
                errors++;
                $display("FAIL stall_hold c%0d: got v=%b d=%h, required v=1 d=11",
                         c, bus4.out_valid[2], bus4.out_data[23:16]);
            end
            if (c == 0) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        bus4.in_data = 8'h33; bus4.in_sel = 2'd1;
        @(negedge clk);
        checks++;
        if (bus4.in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_other_ready: got %b, required 1", bus4.in_ready);
        end
        @(posedge clk); #1;
        bus4.in_data = 8'h22; bus4.in_sel = 2'd2; bus4.out_ready = 4'hF;
        @(negedge clk);
        checks++;
        if (bus4.out_valid[1] !== 1'b1 || bus4.out_data[15:8] !== 8'h33) begin
            errors++;
            $display("FAIL stall_ch1: got v=%b d=%h, required v=1 d=33",
                     bus4.out_valid[1], bus4.out_data[15:8]);
        end
        checks++;
        if (bus4.in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release_ready: got %b, required 1", bus4.in_ready);
        end
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus4.out_valid !== 4'b0100 || bus4.out_data[23:16] !== 8'h22) begin
            errors++;
            $display("FAIL stall_second: got v=%b d=%h, required v=0100 d=22",
                     bus4.out_valid, bus4.out_data[23:16]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus4.out_valid !== 4'h0) begin
            errors++; $display("FAIL stall_empty: got %b, required 0000", bus4.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus4.out_ready = 4'hF;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (i < 8) begin
                bus4.in_data = 8'(i); bus4.in_sel = 2'd3; bus4.in_valid = 1'b1;
            end else begin
                bus4.in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) begin
                checks++;
                if (bus4.in_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready i%0d: got %b, required 1", i, bus4.in_ready);
                end
            end
            if (i >= 1) begin
                checks++;
                if (bus4.out_valid[3] !== 1'b1 || bus4.out_data[31:24] !== 8'(i - 1)) begin
                    errors++;
                    $display("FAIL b2b_beat i%0d: got v=%b d=%h, required v=1 d=%h",
                             i, bus4.out_valid[3], bus4.out_data[31:24], 8'(i - 1));
                end
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus4.out_valid !== 4'h0 || bus4.out_data[31:24] !== 8'h07) begin
            errors++;
            $display("FAIL b2b_tail: got v=%b d=%h, required v=0000 d=07",
                     bus4.out_valid, bus4.out_data[31:24]);
        end
    endtask

    task automatic test_drop();
        bus3.out_ready = 3'b111;
        @(posedge clk); #1;
        bus3.in_data = 8'h5A; bus3.in_sel = 2'd3; bus3.in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus3.in_ready !== 1'b1 || bus3.drop_err !== 1'b0) begin
            errors++;
            $display("FAIL drop_pre: got rdy=%b err=%b, required rdy=1 err=0",
                     bus3.in_ready, bus3.drop_err);
        end
        @(posedge clk); #1;
        bus3.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus3.drop_err !== 1'b1 || bus3.out_valid !== 3'h0) begin
            errors++;
            $display("FAIL drop_pulse: got err=%b v=%b, required err=1 v=000",
                     bus3.drop_err, bus3.out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus3.drop_err !== 1'b0 || bus3.out_valid !== 3'h0) begin
            errors++;
            $display("FAIL drop_after: got err=%b v=%b, required err=0 v=000",
                     bus3.drop_err, bus3.out_valid);
        end
`ifdef DEMUX_BEAT_CNT_EN
        checks++;
        if (drop_cnt3 !== 16'd1) begin
            errors++; $display("FAIL drop_cnt: got %0d, required 1", drop_cnt3);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bus4.out_ready = 4'h0;
        @(posedge clk); #1;
        bus4.in_data = 8'hE0; bus4.in_sel = 2'd0; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_data = 8'hE1; bus4.in_sel = 2'd1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus4.out_valid !== 4'b0011) begin
            errors++; $display("FAIL rmid_filled: got %b, required 0011", bus4.out_valid);
        end
        #2;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        #1;
        checks++;
        if (bus4.out_valid !== 4'h0 || bus4.out_data !== 32'h0) begin
            errors++;
            $display("FAIL rmid_async: got v=%b d=%h, required v=0000 d=0",
                     bus4.out_valid, bus4.out_data);
        end
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus4.in_data = 8'h7E; bus4.in_sel = 2'd0; bus4.in_valid = 1'b1; bus4.out_ready = 4'hF;
        @(negedge clk);
        checks++;
        if (bus4.in_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_ready: got %b, required 1", bus4.in_ready);
        end
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus4.out_valid !== 4'b0001 || bus4.out_data[7:0] !== 8'h7E) begin
            errors++;
            $display("FAIL rmid_beat: got v=%b d=%h, required v=0001 d=7e",
                     bus4.out_valid, bus4.out_data[7:0]);
        end
        @(posedge clk); #1;
    endtask

`ifdef DEMUX_BEAT_CNT_EN
    task automatic test_beat_cnt();
        @(negedge clk); #2;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 4'hF; bus4.in_sel = 2'd0; bus4.in_valid = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            bus4.in_data = 8'(i);
            @(posedge clk); #1;
        end
        bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (beat_cnt4[15:0] !== 16'd1) begin
            errors++; $display("FAIL beat_cnt_wrap: got %0d, required 1", beat_cnt4[15:0]);
        end
        checks++;
        if (beat_cnt4[63:16] !== 48'h0) begin
            errors++; $display("FAIL beat_cnt_others: got %h, required 0", beat_cnt4[63:16]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_route();
        test_stall();
        test_back_to_back();
        test_drop();
        test_reset_mid();
`ifdef DEMUX_BEAT_CNT_EN
        test_beat_cnt();
`endif
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (exp_q[k].size() != 0) begin
                errors++;
                $display("FAIL sb_leftover ch%0d: got %0d pending, required 0", k, exp_q[k].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_1xn.md
Name: stream_demux_1xn

Overview:
- Registered 1-to-NUM_OUT stream demultiplexer with valid/ready handshaking.
- Routes each input beat to the output channel chosen by in_sel, travelling with the beat.
- Each output has a one-entry holding register, so a stalled channel blocks only beats addressed to it.
- Inverse of the team's 2:1 select mux; used wherever one producer feeds several consumers.

Parameters:
- N, 2, data width in bits.
- NUM_OUT, 4, number of output channels (2..16).
- SEL_W, $clog2(NUM_OUT), select width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N  input beat data.
- in_sel  input  SEL_W  destination channel of the current beat.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- out_data  output  NUM_OUT*N  channel k data at bits [k*N +: N].
- out_valid  output  NUM_OUT  per-channel beat present.
- out_ready  input  NUM_OUT  per-channel consumer accepts.
- drop_err  output  1  one-cycle pulse: beat dropped because in_sel >= NUM_OUT.

Behaviour:
- Reset, asynchronous: out_valid=0, out_data=0, drop_err=0. in_ready is combinational and reads 1 while reset is held when in_sel is in range.
- Slot k is full when out_valid[k]=1.
- in_ready, combinational:
  - in_sel < NUM_OUT: in_ready = !out_valid[in_sel] | out_ready[in_sel].
  - in_sel >= NUM_OUT: in_ready = 1.
  - in_ready must not depend on in_valid.
- Accept: in_valid & in_ready at a rising edge.
  - In range: slot in_sel loads in_data and out_valid[in_sel]=1 on the next cycle. Latency is 1 cycle.
  - Out of range: no slot changes; drop_err=1 for exactly the next cycle.
- Drain: out_valid[k] & out_ready[k] empties slot k, unless the same edge loads slot k.
- Simultaneous drain and load on slot k: the slot stays full with the new data, giving full throughput of 1 beat/cycle per channel.
- Channels are independent. Beats to different channels can complete in any order; beats to the same channel stay in order.
- Holding rules:
  - out_data[k] holds its value while out_valid[k]=1 & out_ready[k]=0.
  - out_data[k] keeps its last value when the slot is empty; it is not cleared.
- in_sel may change while in_valid is held low. A producer holding in_valid=1 keeps in_data and in_sel stable until accepted.
- Reset mid-operation: all slots empty immediately and held beats are lost. There is no partial-beat state.
- No state machine beyond per-slot full flags. Per-slot state is EMPTY→FULL on load, FULL→EMPTY on drain without load, FULL→FULL on drain with load or on stall.

Optional Feature:
- Macro: DEMUX_BEAT_CNT_EN.
- When defined:
  - Adds output beat_cnt [NUM_OUT*16-1:0].
  - Channel k has a 16-bit counter of beats drained (out_valid[k] & out_ready[k]).
  - Counters wrap 0xFFFF→0x0000 and reset to 0.
  - Adds output drop_cnt [15:0], counting drop_err pulses, saturating at 0xFFFF.
- When undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package demux_pkg:
  - DEMUX_CNT_W = 16.
  - Default data width constant.
  - Function or macro for channel slice offset (k*N).
- Sub-module demux_slot: one-entry N-bit holding register.
  - Inputs: load, data_in, drain_ready.
  - Outputs: valid, data_out, can_load.
  - Instantiated NUM_OUT times in a generate loop.
- The top level holds select decode, in_ready mux, drop detection and the optional counters.

Test Plan:
- Reset release, all out_ready=1, N=8, NUM_OUT=4. Send 0xA1 sel 0, 0xB2 sel 1, 0xC3 sel 2, 0xD4 sel 3 on consecutive cycles. Each out_valid[k] is high exactly one cycle, one cycle after acceptance, with the matching data; in_ready stays 1.
- out_ready[2]=0. Send 0x11 then 0x22 to sel 2. First is accepted; in_ready=0 for the second while sel=2. Switch in_sel to 1 with 0x33: accepted immediately and out_data[1]=0x33 next cycle. Release out_ready[2]: 0x11 drains, then 0x22 is accepted and presented.
- Back-to-back on channel 3 with out_ready[3]=1 for 8 cycles, data 0x00..0x07. 8 beats arrive in order with no bubble; in_ready never drops.
- NUM_OUT=3, in_sel=3, in_valid=1, data 0x5A. in_ready=1; drop_err pulses exactly one cycle; no out_valid asserts. With DEMUX_BEAT_CNT_EN, drop_cnt=1.
- Fill slots 0 and 1 (out_ready=0), then assert rst_n=0 mid-cycle. out_valid=0 immediately, asynchronously. After release, the next beat 0x7E to sel 0 appears normally.
- With DEMUX_BEAT_CNT_EN, 65537 beats drained on channel 0: beat_cnt[15:0]=1 (wrapped) and the other channel counters remain 0.
